// File: rtl/byte_wr_pkg.sv
// rtl/byte_wr_pkg.sv - lane-count and lane-range helpers for the byte write queue.
// Shared by byte_wr_store and byte_wr_queue; entry type is built from nb().
package byte_wr_pkg;

  function automatic int nb(input int data_w);
    return (data_w - 1) / 8 + 1;
  endfunction

  function automatic int lane_lo(input int k);
    return 8 * k;
  endfunction

  // Top lane is clipped to the data width, so it may be narrower than a byte.
  function automatic int lane_hi(input int k, input int data_w);
    return (8 * k + 7 < data_w) ? 8 * k + 7 : data_w - 1;
  endfunction

  function automatic int entry_w(input int data_w);
    return nb(data_w) + data_w;
  endfunction

endpackage

// File: rtl/byte_wr_store.sv
// rtl/byte_wr_store.sv - DEPTH x {en, d} entry storage with a lane-masked write port.
// Optional merge write port under macro BYTE_WR_MERGE_EN.
module byte_wr_store
  import byte_wr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int NB    = nb(DATA_W),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr,
`ifdef BYTE_WR_MERGE_EN
  input  logic              wr_merge,
`endif
  input  logic [AW-1:0]     wr_addr,
  input  logic [NB-1:0]     wr_en,
  input  logic [DATA_W-1:0] wr_d,
  input  logic [AW-1:0]     rd_addr,
  output logic [NB-1:0]     rd_en,
  output logic [DATA_W-1:0] rd_d
);

  typedef struct packed {
    logic [NB-1:0]     en;
    logic [DATA_W-1:0] d;
  } entry_t;

  entry_t mem [DEPTH];
  entry_t next_entry;

`ifdef BYTE_WR_MERGE_EN
  logic [DATA_W-1:0] lane_mask;

  for (genvar k = 0; k < NB; k++) begin : g_lane
    localparam int LO = lane_lo(k);
    localparam int HI = lane_hi(k, DATA_W);
    assign lane_mask[HI:LO] = {(HI - LO + 1){wr_en[k]}};
  end
`endif

  always_comb begin
    next_entry.en = wr_en;
    next_entry.d  = wr_d;
`ifdef BYTE_WR_MERGE_EN
    // Merge keeps the tail's lanes that the new request does not touch.
    if (wr_merge) begin
      next_entry.en = mem[wr_addr].en | wr_en;
      next_entry.d  = (mem[wr_addr].d & ~lane_mask) | (wr_d & lane_mask);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_addr] <= next_entry;
  end

  assign rd_en = mem[rd_addr].en;
  assign rd_d  = mem[rd_addr].d;

endmodule

// File: rtl/byte_wr_queue.sv
// rtl/byte_wr_queue.sv - byte-enabled write request queue feeding a downstream register.
// Tail merging of requests is enabled by macro BYTE_WR_MERGE_EN.
module byte_wr_queue
  import byte_wr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int NB    = nb(DATA_W),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [NB-1:0]     s_en,
  input  logic [DATA_W-1:0] s_d,
  input  logic              hold,
  output logic              we,
  output logic [NB-1:0]     en,
  output logic [DATA_W-1:0] d,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              accept;
  logic              push;
  logic              pop;
  logic              wr;
  logic [AW-1:0]     wr_addr;
  logic [NB-1:0]     head_en;
  logic [DATA_W-1:0] head_d;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign s_ready = !full;
  assign accept  = s_valid && s_ready;
  assign we      = !empty && !hold;
  assign pop     = we;

`ifdef BYTE_WR_MERGE_EN
  logic          merge;
  logic [AW-1:0] tail_ptr;

  // With one entry issuing this edge, the tail is the head being popped.
  assign tail_ptr = wr_ptr - AW'(1);
  assign merge    = accept && (|s_en) && !empty && !(we && cnt == CW'(1));
  assign push     = accept && (|s_en) && !merge;
  assign wr       = push || merge;
  assign wr_addr  = merge ? tail_ptr : wr_ptr;
`else
  assign push     = accept && (|s_en);
  assign wr       = push;
  assign wr_addr  = wr_ptr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  byte_wr_store #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_store (
    .clk     (clk),
    .wr      (wr),
`ifdef BYTE_WR_MERGE_EN
    .wr_merge(merge),
`endif
    .wr_addr (wr_addr),
    .wr_en   (s_en),
    .wr_d    (s_d),
    .rd_addr (rd_ptr),
    .rd_en   (head_en),
    .rd_d    (head_d)
  );

  // Storage is never reset, so stale entries are hidden whenever nothing issues.
  assign en    = we ? head_en : '0;
  assign d     = we ? head_d  : '0;
  assign count = cnt;

endmodule
